// File: rtl/div_shift_sub.sv
// Sequential restoring divider: shift-subtract, one quotient bit per clock.
// Divides a 2*SIZE-bit unsigned dividend by a SIZE-bit unsigned divisor and
// returns a 2*SIZE-bit quotient and a SIZE-bit remainder. Results and the
// done pulse are registered on the FIN->IDLE edge.
module div_shift_sub #(
  parameter int SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2*SIZE-1:0]   dividend,
  input  logic [SIZE-1:0]     divisor,
  output logic [2*SIZE-1:0]   quotient,
  output logic [SIZE-1:0]     remainder,
  output logic                busy,
  output logic                done,
  output logic                div_zero
);

  localparam int CW = $clog2(2*SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [2*SIZE-1:0]   r_dq;        // dividend shifting out, quotient shifting in
  logic [SIZE:0]       r_r;         // partial remainder, one guard bit wide
  logic [SIZE-1:0]     r_d;         // captured divisor
  logic [CW-1:0]       r_cnt;       // quotient bits still to produce
  logic [2*SIZE-1:0]   r_quotient;
  logic [SIZE-1:0]     r_remainder;
  logic                r_busy;
  logic                r_done;
  logic                r_div_zero;

  logic [SIZE:0]       w_t;         // trial value: remainder shifted with next dividend bit
  logic [SIZE:0]       w_diff;
  logic                w_ge;

  // Trial subtraction for the current quotient bit; the guard bit keeps t>=d exact.
  always_comb begin
    w_t    = {r_r[SIZE-1:0], r_dq[2*SIZE-1]};
    w_ge   = (w_t >= {1'b0, r_d});
    w_diff = w_t - {1'b0, r_d};
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dq        <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (divisor != '0) begin
              r_dq       <= dividend;
              r_r        <= '0;
              r_d        <= divisor;
              r_cnt      <= CW'(2*SIZE);
              r_div_zero <= 1'b0;
              r_state    <= S_CALC;
            end else begin
              // Divide by zero short-circuits straight to FIN with fixed results.
              r_quotient  <= '1;
              r_remainder <= '0;
              r_div_zero  <= 1'b1;
              r_state     <= S_FIN;
            end
          end
        end
        S_CALC: begin
          r_dq  <= {r_dq[2*SIZE-2:0], w_ge};
          r_r   <= w_ge ? w_diff : w_t;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!r_div_zero) begin
            r_quotient  <= r_dq;
            r_remainder <= r_r[SIZE-1:0];
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_div_shift_sub.sv
// Self-checking bench for div_shift_sub (SIZE=8): directed vector table,
// hand-written multi-cycle corner sequences, and random operands checked
// against integer division in the bench.
module tb_div_shift_sub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_pass;
  int n_tot;

  div_shift_sub #(.SIZE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  // Called at a negedge. Issues start, returns at the negedge where done is
  // seen (or after a bounded wait), with the number of edges from accept.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r,
                       output logic dz, output int lat);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    q = quotient; r = remainder; dz = div_zero;
  endtask

  logic [15:0] q;
  logic [7:0]  r;
  logic        dz;
  int          lat;
  int          saw;

  initial begin
    n_pass = 0; n_tot = 0;
    vt[0] = '{16'd315,   8'd21,  16'd15,    8'd0,  1'b0, 17};
    vt[1] = '{16'd330,   8'd21,  16'd15,    8'd15, 1'b0, 17};
    vt[2] = '{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, 17};
    vt[3] = '{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0, 17};
    vt[4] = '{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0, 17};
    vt[5] = '{16'd0,     8'd9,   16'd0,     8'd0,  1'b0, 17};
    vt[6] = '{16'd5,     8'd200, 16'd0,     8'd5,  1'b0, 17};
    vt[7] = '{16'd100,   8'd0,   16'hFFFF,  8'd0,  1'b1, 1};
    vt[8] = '{16'd8,     8'd2,   16'd4,     8'd0,  1'b0, 17};

    // Reset held with start asserted: nothing may start.
    rst_n = 1'b0; start = 1'b1; dividend = 16'd315; divisor = 8'd21;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quot", quotient, 0);
      chk("rst_rem", remainder, 0);
      chk("rst_dz", div_zero, 0);
    end
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back-to-back (each start in the done cycle).
    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].a, vt[i].b, q, r, dz, lat);
      chk($sformatf("vec%0d_quot", i), q, vt[i].q);
      chk($sformatf("vec%0d_rem", i), r, vt[i].r);
      chk($sformatf("vec%0d_dz", i), dz, vt[i].dz);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);

    // Start ignored while busy: 9/3 pulsed mid-calculation.
    start = 1'b1; dividend = 16'd315; divisor = 8'd21;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 4) begin
        start = 1'b1; dividend = 16'd9; divisor = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); lat++; @(negedge clk);
      if (lat == 3) chk("calc_busy", busy, 1);
    end
    start = 1'b0;
    chk("ign_quot", quotient, 15);
    chk("ign_rem", remainder, 0);
    chk("ign_lat", lat, 17);
    @(negedge clk);
    chk("ign_no_requeue_busy", busy, 0);

    // Reset mid-calculation: operation abandoned, no done pulse.
    start = 1'b1; dividend = 16'd315; divisor = 8'd21;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    saw = 0;
    for (int k = 1; k <= 30; k++) begin
      rst_n = (k == 8) ? 1'b0 : 1'b1;
      @(posedge clk); @(negedge clk);
      if (done) saw++;
    end
    rst_n = 1'b1;
    chk("rstmid_no_done", saw, 0);
    chk("rstmid_quot", quotient, 0);
    chk("rstmid_rem", remainder, 0);
    chk("rstmid_busy", busy, 0);
    do_op(16'd8, 8'd2, q, r, dz, lat);
    chk("post_rst_quot", q, 4);
    chk("post_rst_lat", lat, 17);

    // Random operands against plain integer division.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (i % 3 == 0) @(negedge clk);
      do_op(a, b, q, r, dz, lat);
      if (b == 0) begin
        chk("rnd_dz_quot", q, 16'hFFFF);
        chk("rnd_dz_rem", r, 0);
        chk("rnd_dz_flag", dz, 1);
        chk("rnd_dz_lat", lat, 1);
      end else begin
        chk("rnd_quot", q, 32'(a) / 32'(b));
        chk("rnd_rem", r, 32'(a) % 32'(b));
        chk("rnd_dz_flag", dz, 0);
        chk("rnd_lat", lat, 17);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
